// File: rtl/branch_resolver.sv
// Branch resolver: carries BTB predictions through IF_ID/ID_EX, resolves them in EX,
// raises flush/redirect on mispredict and issues one registered BTB update per resolution.
module branch_resolver #(
  parameter int PC_W  = 16,
  parameter int IDX_W = 9,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic [PC_W-1:0]       pc_IF,
  input  logic                  pred_hit_IF,
  input  logic                  pred_strong_IF,
  input  logic [PC_W-1:0]       pred_target_IF,
  input  logic                  br_instr_EX,
  input  logic                  taken_EX,
  input  logic [PC_W-1:0]       target_EX,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [PC_W-1:0]       redirect_pc,
  output logic                  upd_we,
  output logic [IDX_W-1:0]      upd_index,
  output logic [PC_W-IDX_W-1:0] upd_tag,
  output logic                  upd_strong,
  output logic                  upd_valid,
  output logic [PC_W-1:0]       upd_target,
  input  logic                  perf_clr,
  output logic [CNT_W-1:0]      br_cnt,
  output logic [CNT_W-1:0]      mis_cnt
);

  localparam int TAG_W = PC_W - IDX_W;
  localparam logic [PC_W-1:0]  PC_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [PC_W-1:0]  id_pc, id_tgt, ex_pc, ex_tgt;
  logic             id_hit, id_s, ex_hit, ex_s;

  logic             mis, wr, nxt_s, nxt_v;
  logic [PC_W-1:0]  rpc, nxt_tgt, pc_inc;
  logic [TAG_W-1:0] nxt_tag;
  logic [IDX_W-1:0] nxt_idx;

  assign pc_inc = ex_pc + PC_ONE;

  // Priority-ordered resolution of the EX-stage prediction. An invalidate is a write
  // with every field left at its zero default; only the index is taken from pc.
  always_comb begin
    mis     = 1'b0;
    wr      = 1'b0;
    rpc     = '0;
    nxt_s   = 1'b0;
    nxt_v   = 1'b0;
    nxt_tgt = '0;
    nxt_tag = '0;
    nxt_idx = '0;
    if (!stall) begin
      if (ex_hit && !br_instr_EX) begin
        mis = 1'b1;
        rpc = pc_inc;
        wr  = 1'b1;
      end else if (ex_hit && !taken_EX) begin
        mis = 1'b1;
        rpc = pc_inc;
        wr  = 1'b1;
        if (ex_s) begin
          nxt_tag = ex_pc[PC_W-1:IDX_W];
          nxt_v   = 1'b1;
          nxt_tgt = ex_tgt;
        end
      end else if (ex_hit && (ex_tgt != target_EX)) begin
        mis     = 1'b1;
        rpc     = target_EX;
        wr      = 1'b1;
        nxt_tag = ex_pc[PC_W-1:IDX_W];
        nxt_v   = 1'b1;
        nxt_tgt = target_EX;
      end else if (ex_hit) begin
        if (!ex_s) begin
          wr      = 1'b1;
          nxt_tag = ex_pc[PC_W-1:IDX_W];
          nxt_s   = 1'b1;
          nxt_v   = 1'b1;
          nxt_tgt = ex_tgt;
        end
      end else if (br_instr_EX && taken_EX) begin
        mis     = 1'b1;
        rpc     = target_EX;
        wr      = 1'b1;
        nxt_tag = ex_pc[PC_W-1:IDX_W];
        nxt_v   = 1'b1;
        nxt_tgt = target_EX;
      end
      if (wr) nxt_idx = ex_pc[IDX_W-1:0];
    end
  end

  assign flush          = mis;
  assign redirect_valid = mis;
  assign redirect_pc    = rpc;

  // Prediction pipeline: holds on stall, squashed to an empty slot on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_pc <= '0; id_hit <= 1'b0; id_s <= 1'b0; id_tgt <= '0;
      ex_pc <= '0; ex_hit <= 1'b0; ex_s <= 1'b0; ex_tgt <= '0;
    end else if (!stall) begin
      if (mis) begin
        id_pc <= '0; id_hit <= 1'b0; id_s <= 1'b0; id_tgt <= '0;
        ex_pc <= '0; ex_hit <= 1'b0; ex_s <= 1'b0; ex_tgt <= '0;
      end else begin
        id_pc <= pc_IF;  id_hit <= pred_hit_IF; id_s <= pred_strong_IF; id_tgt <= pred_target_IF;
        ex_pc <= id_pc;  ex_hit <= id_hit;      ex_s <= id_s;           ex_tgt <= id_tgt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_we     <= 1'b0;
      upd_index  <= '0;
      upd_tag    <= '0;
      upd_strong <= 1'b0;
      upd_valid  <= 1'b0;
      upd_target <= '0;
    end else begin
      upd_we     <= wr;
      upd_index  <= nxt_idx;
      upd_tag    <= nxt_tag;
      upd_strong <= nxt_s;
      upd_valid  <= nxt_v;
      upd_target <= nxt_tgt;
    end
  end

  // Saturating counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else if (perf_clr) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else begin
      if (br_instr_EX && !stall && (br_cnt != '1)) br_cnt <= br_cnt + CNT_ONE;
      if (mis && (mis_cnt != '1)) mis_cnt <= mis_cnt + CNT_ONE;
    end
  end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Branch resolution unit at the EX end of the BTB prediction path. Carries each fetched instruction's BTB prediction (hit, strong bit, predicted target) alongside the IF_ID and ID_EX pipeline registers. Compares it against the real outcome in EX, then:
- issues flush and redirect on mispredict;
- emits one registered update command to the BTB write port;
- keeps saturating branch and mispredict counters.

## Interface
Parameters:
- PC_W, 16, PC and target width
- IDX_W, 9, BTB index width; tag width is PC_W-IDX_W
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  clock; all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  pipeline hold; IF_ID/ID_EX copies hold, EX resolution suppressed
- pc_IF  in  PC_W  un-incremented PC of instruction in IF
- pred_hit_IF  in  1  BTB hit for pc_IF
- pred_strong_IF  in  1  strong bit of hit entry
- pred_target_IF  in  PC_W  predicted target
- br_instr_EX  in  1  instruction in EX is a branch/jump
- taken_EX  in  1  actual flow change in EX
- target_EX  in  PC_W  actual target in EX
- flush  out  1  kill IF_ID and ID_EX contents
- redirect_valid  out  1  load redirect_pc into PC
- redirect_pc  out  PC_W  corrected fetch address
- upd_we  out  1  BTB write strobe, one-cycle pulse
- upd_index  out  IDX_W  BTB write index
- upd_tag  out  PC_W-IDX_W  tag field
- upd_strong, upd_valid  out  1 each  S and V fields
- upd_target  out  PC_W  target field
- perf_clr  in  1  synchronous clear of counters
- br_cnt, mis_cnt  out  CNT_W each  resolved branches / mispredicts

## Operation
Internal pipeline:
- IF_ID and ID_EX copies of {pc, hit, strong, target}.
- Advance on posedge when stall=0; hold when stall=1.
- On a cycle with flush=1 and stall=0, both copies load hit=0, strong=0, pc=0, target=0.

EX fields: pc_X, hit_X, s_X, tgt_X. Resolution is evaluated only when stall=0. Case order is priority:
- hit_X & ~br_instr_EX: alias. Mispredict; redirect pc_X+1; invalidate.
- hit_X & br & ~taken: mispredict; redirect pc_X+1.
  - s_X=1: write S=0, V=1, target tgt_X (retain).
  - s_X=0: invalidate.
- hit_X & br & taken & tgt_X != target_EX: mispredict; redirect target_EX; write S=0, V=1, target target_EX.
- hit_X & br & taken & match: correct. If s_X=0, write S=1, V=1, target tgt_X; otherwise no write.
- ~hit_X & br & taken: mispredict; redirect target_EX; allocate S=0, V=1, target target_EX.
- ~hit_X & (~br | ~taken): correct, no write.

Field and arithmetic rules:
- Invalidate writes all fields 0.
- Every non-invalidate write uses upd_index = pc_X[IDX_W-1:0] and upd_tag = pc_X[PC_W-1:IDX_W].
- pc_X+1 wraps modulo 2^PC_W.

Mispredict outputs: flush = redirect_valid = 1 in the same cycle.

Counters:
- br_cnt increments on each resolved branch (br_instr_EX=1, stall=0).
- mis_cnt increments on each mispredict.
- Both saturate at all-ones.
- perf_clr has priority over a same-cycle increment.

## Timing
- Reset: all pipeline copies 0 and counters 0. flush, redirect_valid, upd_we and all upd_* fields are 0; redirect_pc is 0.
- An instruction in IF at cycle n with stall=0 throughout reaches EX at n+2.
- flush, redirect_valid and redirect_pc are combinational from EX inputs in cycle n+2.
- upd_* are registered: valid in n+3 for exactly one cycle, then return to 0.
- Counters reflect the n+2 event from n+3.
- stall=1 in EX: no flush, redirect, write or count. Resolution happens once, in the first stall=0 cycle.
- Back-to-back resolutions produce back-to-back upd_we pulses; there is no buffering beyond one register.
- Reset asserted mid-operation clears everything immediately, including a pending upd_we.

## Test plan
- Cold allocate:
  - Stimulus: pc_IF=0x1234, hit=0, in EX br=1, taken=1, target_EX=0x0040.
  - n+2: flush=1, redirect_pc=0x0040.
  - n+3: upd_we=1, index=0x034, tag=0x09, S=0, V=1, target=0x0040; mis_cnt=1, br_cnt=1.
- Strengthen:
  - Stimulus: hit=1, s=0, tgt=0x0040, EX taken to 0x0040.
  - No flush; upd_we with S=1, target 0x0040; mis_cnt unchanged.
- Strong not-taken:
  - Stimulus: hit=1, s=1, pc 0x0100, EX br=1, taken=0.
  - redirect_pc=0x0101; write S=0, V=1, target retained. A second weak not-taken invalidates (all-zero write).
- Wrap and alias:
  - Stimulus: pc_IF=0xFFFF with hit=1, EX non-branch.
  - redirect_pc=0x0000; invalidate at index 0x1FF.
- Stall:
  - Stimulus: mispredict sits in EX with stall=1 for 3 cycles.
  - No outputs during the stall; a single flush and single upd_we after release; counters +1 only.
- Counters:
  - Preload to 0xFFFF; further mispredicts hold 0xFFFF.
  - perf_clr coincident with a mispredict yields 0.
